// File: rtl/button_pkg.sv
// ---------------------------------------------------------------------------
// button_pkg
//
// Shared types and helpers for the push-button conditioning block.
//
// Contents:
//   btn_state_t  - per-button debounce state machine encoding
//   count_width  - bits needed to hold a counter that runs 0..max_count
//
// No ports (package).
// ---------------------------------------------------------------------------
package button_pkg;

  // The two "stable" states track the committed level. The two "wait"
  // states are debounce windows in which the synchronised pin disagrees
  // with the committed level.
  typedef enum logic [1:0] {
    BTN_UP        = 2'b00,
    BTN_WAIT_DOWN = 2'b01,
    BTN_DOWN      = 2'b10,
    BTN_WAIT_UP   = 2'b11
  } btn_state_t;

  // Width of a counter that must represent every value from 0 up to and
  // including max_count without wrapping.
  function automatic int count_width(input int unsigned max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage : button_pkg

// File: rtl/button_channel.sv
// ---------------------------------------------------------------------------
// button_channel
//
// Conditions a single push-button: polarity fix, two-flop synchroniser,
// counter-based debounce FSM, one-cycle press/release pulses, a sticky
// press flag with write-1-to-clear, and an optional long-press detector.
//
// Optional feature: define BUTTON_LONGPRESS_EN to build the hold counter
// that drives longpress. Without it longpress is tied low.
//
// Ports:
//   clk        in   1  the only clock
//   reset      in   1  synchronous, active-high
//   pin        in   1  raw button pin, asynchronous
//   event_clr  in   1  write-1-to-clear for event_q
//   level      out  1  debounced state, 1 = pressed
//   pressed    out  1  one-cycle pulse on a committed press
//   released   out  1  one-cycle pulse on a committed release
//   event_q    out  1  sticky press flag
//   longpress  out  1  one-cycle pulse after a long hold
// ---------------------------------------------------------------------------
module button_channel
  import button_pkg::*;
#(
  parameter bit          ACTIVE_LOW       = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES  = 240000,
  parameter int unsigned LONGPRESS_CYCLES = 24000000
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  input  logic event_clr,
  output logic level,
  output logic pressed,
  output logic released,
  output logic event_q,
  output logic longpress
);

  localparam int CNT_W = count_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic       pin_pressed;
  logic       s;

  btn_state_t state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic       level_d, level_q;
  logic       pressed_d, pressed_q;
  logic       released_d, released_q;
  logic       event_d;

  // Normalise polarity before synchronising so that "pressed" is always 1
  // internally and the synchroniser's reset value means "released".
  assign pin_pressed = ACTIVE_LOW ? ~pin : pin;

  sync #(
    .WIDTH(1)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (pin_pressed),
    .q    (s)
  );

  // Debounce state machine. A change is only committed after the
  // synchronised input has disagreed with the committed level for
  // DEBOUNCE_CYCLES consecutive cycles; any agreement in between drops
  // back to the stable state and zeroes the counter, so a bounce restarts
  // the whole window. Commit also zeroes the counter, and since commit
  // happens exactly at CNT_MAX the counter can never wrap.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    level_d    = level_q;
    pressed_d  = 1'b0;
    released_d = 1'b0;

    unique case (state_q)
      BTN_UP: begin
        if (s != level_q) begin
          state_d = BTN_WAIT_DOWN;
          cnt_d   = CNT_ONE;
        end
      end

      BTN_WAIT_DOWN: begin
        if (s == level_q) begin
          state_d = BTN_UP;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = BTN_DOWN;
          cnt_d     = '0;
          level_d   = 1'b1;
          pressed_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      BTN_DOWN: begin
        if (s != level_q) begin
          state_d = BTN_WAIT_UP;
          cnt_d   = CNT_ONE;
        end
      end

      BTN_WAIT_UP: begin
        if (s == level_q) begin
          state_d = BTN_DOWN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d    = BTN_UP;
          cnt_d      = '0;
          level_d    = 1'b0;
          released_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = BTN_UP;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  // The sticky flag is registered from the already-registered pressed
  // pulse, so it rises one cycle after pressed. Setting takes priority
  // over a simultaneous clear so a press can never be lost.
  always_comb begin
    event_d = pressed_q | (event_q & ~event_clr);
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BTN_UP;
      cnt_q      <= '0;
      level_q    <= 1'b0;
      pressed_q  <= 1'b0;
      released_q <= 1'b0;
      event_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      level_q    <= level_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
      event_q    <= event_d;
    end
  end

  assign level    = level_q;
  assign pressed  = pressed_q;
  assign released = released_q;

`ifdef BUTTON_LONGPRESS_EN

  localparam int HOLD_W = count_width(LONGPRESS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONGPRESS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONGPRESS_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  logic [HOLD_W-1:0] hold_d, hold_q;
  logic              longpress_d, longpress_q;

  // Hold counter runs for as long as the committed level is "pressed",
  // including while a release is still being debounced, so a bounce on
  // the way up does not restart the hold time. It saturates at
  // HOLD_MAX and pulses longpress on the single step that reaches it.
  // Only a committed release clears it; on that same edge no long-press
  // pulse is allowed, which keeps released and longpress mutually
  // exclusive.
  always_comb begin
    hold_d      = hold_q;
    longpress_d = 1'b0;

    if (released_d) begin
      hold_d = '0;
    end else if (((state_q == BTN_DOWN) || (state_q == BTN_WAIT_UP)) &&
                 (hold_q != HOLD_MAX)) begin
      hold_d      = hold_q + HOLD_ONE;
      longpress_d = (hold_q == HOLD_PRE);
    end
  end

  // Hold counter and long-press pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q      <= '0;
      longpress_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      longpress_q <= longpress_d;
    end
  end

  assign longpress = longpress_q;

`else

  // No hold counter in this build; the hold time parameter has no effect.
  logic unused_longpress_cycles;
  assign unused_longpress_cycles = ^LONGPRESS_CYCLES;

  assign longpress = 1'b0;

`endif

endmodule : button_channel

// File: rtl/sync.sv
// ---------------------------------------------------------------------------
// sync
//
// Two-flop synchroniser for asynchronous level inputs. Reset clears both
// stages to zero, so the caller must present its "idle" value as 0.
//
// Ports:
//   clk    in   1      sampling clock
//   reset  in   1      synchronous, active-high; both stages load 0
//   d      in   WIDTH  asynchronous input
//   q      out  WIDTH  synchronised output (two clock edges of latency)
// ---------------------------------------------------------------------------
module sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage1_d;
  logic [WIDTH-1:0] stage1_q;
  logic [WIDTH-1:0] stage2_d;
  logic [WIDTH-1:0] stage2_q;

  // The first stage may go metastable; the second stage gives it a full
  // clock period to resolve before anything downstream looks at it.
  always_comb begin
    stage1_d = d;
    stage2_d = stage1_q;
  end

  // Stage registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage1_q <= '0;
      stage2_q <= '0;
    end else begin
      stage1_q <= stage1_d;
      stage2_q <= stage2_d;
    end
  end

  assign q = stage2_q;

endmodule : sync

// File: rtl/button_debounce.sv
// ---------------------------------------------------------------------------
// button_debounce
//
// Conditions the raw board push-buttons before they reach the core. Each
// button is handled by an independent button_channel, so simultaneous
// commits on several buttons all pulse in the same cycle.
//
// Optional feature: define BUTTON_LONGPRESS_EN to enable per-button
// long-press detection. Without it the longpress port is always 0.
//
// Ports:
//   clk         in   1            PLL clock; the only clock
//   reset       in   1            synchronous, active-high
//   buttons_in  in   BUTTONCOUNT  raw pins, asynchronous
//   level       out  BUTTONCOUNT  debounced state, 1 = pressed
//   pressed     out  BUTTONCOUNT  one-cycle pulse on a committed press
//   released    out  BUTTONCOUNT  one-cycle pulse on a committed release
//   event_q     out  BUTTONCOUNT  sticky press flags
//   event_clr   in   BUTTONCOUNT  write-1-to-clear for event_q
//   longpress   out  BUTTONCOUNT  one-cycle long-press pulse
// ---------------------------------------------------------------------------
module button_debounce
  import button_pkg::*;
#(
  parameter int          BUTTONCOUNT      = 4,
  parameter bit          ACTIVE_LOW       = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES  = 240000,
  parameter int unsigned LONGPRESS_CYCLES = 24000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BUTTONCOUNT-1:0] buttons_in,
  output logic [BUTTONCOUNT-1:0] level,
  output logic [BUTTONCOUNT-1:0] pressed,
  output logic [BUTTONCOUNT-1:0] released,
  output logic [BUTTONCOUNT-1:0] event_q,
  input  logic [BUTTONCOUNT-1:0] event_clr,
  output logic [BUTTONCOUNT-1:0] longpress
);

  // One fully self-contained channel per button; they share nothing but
  // the clock and reset.
  for (genvar i = 0; i < BUTTONCOUNT; i++) begin : g_channel
    button_channel #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONGPRESS_CYCLES(LONGPRESS_CYCLES)
    ) u_channel (
      .clk      (clk),
      .reset    (reset),
      .pin      (buttons_in[i]),
      .event_clr(event_clr[i]),
      .level    (level[i]),
      .pressed  (pressed[i]),
      .released (released[i]),
      .event_q  (event_q[i]),
      .longpress(longpress[i])
    );
  end

endmodule : button_debounce
